// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the fetch and data ports
module mem_port_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int MAX_DSTREAK = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic          if_ack_o,
    output logic [DW-1:0] if_rdata_o,
    input  logic          dm_req_i,
    input  logic          dm_we_i,
    input  logic [AW-1:0] dm_addr_i,
    input  logic [DW-1:0] dm_wdata_i,
    output logic          dm_ack_o,
    output logic [DW-1:0] dm_rdata_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic          mem_ack_i,
    input  logic [DW-1:0] mem_rdata_i,
    output logic          err_o,
    output logic          stall_o,
    output logic [1:0]    grant_o
);
    localparam int SW = $clog2(MAX_DSTREAK + 1);
    localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t        state, state_n;
    logic [SW-1:0] streak;
    logic [TW-1:0] tcnt;
    logic          pick_dm, pick_if, tout, done;

    // data wins unless fetch is waiting and data already had its streak
    assign pick_dm = dm_req_i && (!if_req_i || streak < SW'(MAX_DSTREAK));
    assign pick_if = if_req_i && !pick_dm;
    assign tout    = (TIMEOUT > 0) && tcnt == TW'(TIMEOUT - 1);
    assign done    = mem_ack_i || tout;
    assign stall_o = (if_req_i && !if_ack_o) || (dm_req_i && !dm_ack_o);

    // state register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_n;
    end

    // next state: grant from IDLE, finish on ack or timeout, one response cycle
    always_comb begin
        state_n = state;
        state_n = state == IDLE ? ((pick_dm || pick_if) ? BUSY : IDLE)
                : state == BUSY ? (done ? RESP : BUSY)
                : IDLE;
    end

    // memory-side registers, completion pulses, streak and timeout counters
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            if_ack_o    <= 1'b0;
            dm_ack_o    <= 1'b0;
            if_rdata_o  <= '0;
            dm_rdata_o  <= '0;
            err_o       <= 1'b0;
            grant_o     <= 2'b00;
            streak      <= '0;
            tcnt        <= '0;
        end else begin
            if_ack_o <= 1'b0;
            dm_ack_o <= 1'b0;
            err_o    <= 1'b0;
            if (state == IDLE && (pick_dm || pick_if)) begin
                mem_req_o   <= 1'b1;
                mem_we_o    <= pick_dm && dm_we_i;
                mem_addr_o  <= pick_dm ? dm_addr_i : if_addr_i;
                mem_wdata_o <= pick_dm ? dm_wdata_i : '0;
                grant_o     <= {pick_dm, pick_if};
                streak      <= (pick_dm && if_req_i) ? streak + 1'b1 : '0;
                tcnt        <= '0;
            end
            if (state == BUSY) begin
                tcnt <= tcnt + 1'b1;
                if (done) begin
                    mem_req_o <= 1'b0;
                    if_ack_o  <= grant_o[0];
                    dm_ack_o  <= grant_o[1];
                    err_o     <= !mem_ack_i;
                    if (grant_o[0]) if_rdata_o <= mem_ack_i ? mem_rdata_i : '0;
                    if (grant_o[1] && !(mem_ack_i && mem_we_o)) dm_rdata_o <= mem_ack_i ? mem_rdata_i : '0;
                end
            end
            if (state == RESP) grant_o <= 2'b00;
        end
    end
endmodule
